// File: rtl/uart_pkt_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkt_pkg
//  Purpose  : Shared types and constants for the UART packet decoder slice.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkt_pkg;

    typedef enum logic [2:0] {
        HUNT    = 3'd0,
        CMD     = 3'd1,
        LEN     = 3'd2,
        PAYLOAD = 3'd3,
        CHK     = 3'd4,
        HOLD    = 3'd5
    } state_t;

    localparam logic [1:0] ERR_OVERRUN = 2'd0;
    localparam logic [1:0] ERR_CHK     = 2'd1;
    localparam logic [1:0] ERR_LEN     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hAA;
    localparam logic [7:0] CRC8_POLY         = 8'h07;

endpackage
`default_nettype wire

// File: rtl/pkt_check_accum.sv
`default_nettype none
// ============================================================================
//  Module   : pkt_check_accum
//  Purpose  : Byte-serial frame check accumulator; sum8 by default, CRC-8
//             (poly 0x07, MSB-first) when PKT_CRC8_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module pkt_check_accum
    import uart_pkt_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic [7:0] i_byte,
    output logic [7:0] o_value
);

    logic [7:0] acc_q;
    logic [7:0] acc_d;

`ifdef PKT_CRC8_EN
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] b);
        logic [7:0] c;
        c = crc ^ b;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

    always_comb begin
        acc_d = acc_q;
        if (i_clr)
            acc_d = 8'h00;
        else if (i_en)
            acc_d = crc8_step(acc_q, i_byte);
    end
`else
    always_comb begin
        acc_d = acc_q;
        if (i_clr)
            acc_d = 8'h00;
        else if (i_en)
            acc_d = acc_q + i_byte;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst)
            acc_q <= 8'h00;
        else
            acc_q <= acc_d;
    end

    assign o_value = acc_q;

endmodule
`default_nettype wire

// File: rtl/uart_packet_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : uart_packet_decoder
//  Purpose  : Sync-hunting frame decoder behind the UART receiver; holds good
//             frames for the command logic. PKT_CRC8_EN selects CRC-8 check.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_packet_decoder
    import uart_pkt_pkg::*;
#(
    parameter int         MAX_LEN        = 16,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter int         ADDR_W         = $clog2(MAX_LEN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_new_data,
    output logic              pkt_valid,
    output logic [7:0]        pkt_cmd,
    output logic [7:0]        pkt_len,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    input  logic              pkt_ack,
    output logic              pkt_err,
    output logic [1:0]        err_code
);

    localparam logic [7:0] c_max_len = 8'(MAX_LEN);
    localparam int         c_tmo_w   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT_CYCLES - 1);

    state_t               state_q, state_d;
    logic [7:0]           cmd_q, cmd_d;
    logic [7:0]           len_q, len_d;
    logic [7:0]           idx_q, idx_d;
    logic [c_tmo_w-1:0]   tmo_q, tmo_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    logic [1:0]           code_q, code_d;
    logic [7:0]           rd_data_q;
    logic [7:0]           pay_mem [MAX_LEN];

    logic                 acc_clr;
    logic                 acc_en;
    logic                 wr_en;
    logic                 chk_good;
    logic [7:0]           acc_value;

    pkt_check_accum u_accum (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (acc_clr),
        .i_en    (acc_en),
        .i_byte  (rx_data),
        .o_value (acc_value)
    );

`ifdef PKT_CRC8_EN
    assign chk_good = (rx_data == acc_value);
`else
    assign chk_good = ((acc_value + rx_data) == 8'h00);
`endif

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        len_d   = len_q;
        idx_d   = idx_q;
        tmo_d   = tmo_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        code_d  = code_q;
        acc_clr = 1'b0;
        acc_en  = 1'b0;
        wr_en   = 1'b0;

        // Inter-byte watchdog only runs while a frame is partially received.
        if (state_q inside {CMD, LEN, PAYLOAD, CHK}) begin
            if (rx_new_data) begin
                tmo_d = '0;
            end else if (tmo_q == c_tmo_last) begin
                tmo_d   = '0;
                err_d   = 1'b1;
                code_d  = ERR_TIMEOUT;
                state_d = HUNT;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end

        case (state_q)
            HUNT: begin
                if (rx_new_data && rx_data == SYNC_BYTE) begin
                    acc_clr = 1'b1;
                    state_d = CMD;
                end
            end
            CMD: begin
                if (rx_new_data) begin
                    cmd_d   = rx_data;
                    acc_en  = 1'b1;
                    state_d = LEN;
                end
            end
            LEN: begin
                if (rx_new_data) begin
                    idx_d = 8'h00;
                    if (rx_data > c_max_len) begin
                        err_d   = 1'b1;
                        code_d  = ERR_LEN;
                        state_d = HUNT;
                    end else begin
                        len_d   = rx_data;
                        acc_en  = 1'b1;
                        state_d = (rx_data == 8'h00) ? CHK : PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (rx_new_data) begin
                    wr_en  = 1'b1;
                    acc_en = 1'b1;
                    idx_d  = idx_q + 8'h01;
                    if (idx_q == len_q - 8'h01)
                        state_d = CHK;
                end
            end
            CHK: begin
                if (rx_new_data) begin
                    if (chk_good) begin
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = ERR_CHK;
                        state_d = HUNT;
                    end
                end
            end
            HOLD: begin
                // Ack wins over a coincident byte, which is then treated as a hunt byte.
                if (pkt_ack) begin
                    valid_d = 1'b0;
                    state_d = HUNT;
                    if (rx_new_data && rx_data == SYNC_BYTE) begin
                        acc_clr = 1'b1;
                        state_d = CMD;
                    end
                end else if (rx_new_data) begin
                    err_d  = 1'b1;
                    code_d = ERR_OVERRUN;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= HUNT;
            cmd_q     <= 8'h00;
            len_q     <= 8'h00;
            idx_q     <= 8'h00;
            tmo_q     <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= 2'b00;
            rd_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            tmo_q     <= tmo_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            code_q    <= code_d;
            rd_data_q <= pay_mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            pay_mem[idx_q[ADDR_W-1:0]] <= rx_data;
    end

    assign pkt_valid = valid_q;
    assign pkt_cmd   = cmd_q;
    assign pkt_len   = len_q;
    assign rd_data   = rd_data_q;
    assign pkt_err   = err_q;
    assign err_code  = code_q;

endmodule
`default_nettype wire
